joy_serializer: RTL and testbench

JOY_SERIALIZER -- requirements
Module: joy_serializer

---
 rtl/joy_pkg.sv | 20 ++
 rtl/sync_edge.sv | 31 +++
 rtl/joy_serializer.sv | 110 +++++++++++
 tb/tb_joy_serializer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// rtl/joy_pkg.sv - shared constants and state type for the joystick serializer
package joy_pkg;

  localparam int JOY_UP    = 7;
  localparam int JOY_DOWN  = 6;
  localparam int JOY_LEFT  = 5;
  localparam int JOY_RIGHT = 4;
  localparam int JOY_FIRE1 = 3;
  localparam int JOY_FIRE2 = 2;
  localparam int JOY_FIRE3 = 1;
  localparam int JOY_START = 0;

  localparam int FRAME_BITS = 16;

  typedef enum logic {
    LOAD,
    SHIFT
  } joy_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_serializer.sv
// rtl/joy_serializer.sv - two-pad joystick parallel-load/serial-shift emulation for a host decoder
module joy_serializer
  import joy_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  output logic       joy_data,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] SAT_CNT  = 5'(FRAME_BITS);

  logic clk_level, clk_rise, clk_fall;
  logic load_n_level, load_rise, load_fall;
  logic unused_edges;

  joy_state_e state, state_next;
  logic       do_load, do_shift;

  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame;
  logic [4:0]            bit_cnt;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (joy_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .din   (joy_load_n),
    .level (load_n_level),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  assign unused_edges = ^{clk_level, clk_fall, load_rise, load_fall};
  assign frame        = {joy2, joy1};

  // The cycle that leaves LOAD neither loads nor shifts, so the register freezes.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    case (state)
      LOAD: begin
        if (load_n_level) begin
          state_next = SHIFT;
        end else begin
          do_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!load_n_level) begin
          state_next = LOAD;
          do_load    = 1'b1;
        end else begin
          do_shift = clk_rise;
        end
      end
      default: state_next = SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHIFT;
      shreg      <= 16'hFFFF;
      joy_data   <= 1'b1;
      bit_cnt    <= 5'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      if (do_load) begin
        shreg    <= frame;
        joy_data <= frame[0];
        bit_cnt  <= 5'd0;
        overrun  <= 1'b0;
      end else if (do_shift) begin
        shreg <= {FILL_BIT, shreg[FRAME_BITS-1:1]};
        if (bit_cnt >= LAST_BIT) begin
          overrun  <= 1'b1;
          bit_cnt  <= SAT_CNT;
          joy_data <= FILL_BIT;
        end else begin
          bit_cnt    <= bit_cnt + 5'd1;
          joy_data   <= shreg[1];
          frame_done <= (bit_cnt == LAST_BIT - 5'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_serializer.sv
// tb/tb_joy_serializer.sv - scoreboard bench driving a host-decoder model against joy_serializer
module tb_joy_serializer;

  localparam int HALF = 128;
  localparam int K_DATA = 0;
  localparam int K_OVR  = 1;
  localparam int K_FD   = 2;
  localparam int K_CNT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       joy_clk = 1'b0;
  logic       joy_load_n = 1'b1;
  logic [7:0] joy1 = 8'hFF;
  logic [7:0] joy2 = 8'hFF;
  logic       joy_data, frame_done, overrun;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  logic sample_req = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_count = 0;
  int   exp_fd = 0;

  joy_serializer #(.SYNC_STAGES(2), .FILL_BIT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load_n (joy_load_n),
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: counts frame_done pulses and checks queued expectations on request.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (frame_done === 1'b1) fd_count++;
    if (sample_req) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: sample requested with no expectation");
      end else begin
        e = q.pop_front();
        case (e.kind)
          K_DATA:  act = (joy_data === 1'b1) ? 1 : (joy_data === 1'b0) ? 0 : -1;
          K_OVR:   act = (overrun === 1'b1) ? 1 : (overrun === 1'b0) ? 0 : -1;
          K_FD:    act = fd_count;
          default: act = int'(dut.bit_cnt);
        endcase
        if (act != e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input int exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1 sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
  endtask

  task automatic begin_load(input logic [15:0] f, input string tag);
    joy1 = f[7:0];
    joy2 = f[15:8];
    joy_load_n = 1'b0;
    wait_clk(2 * HALF);
    chk(K_DATA, int'(f[0]), {tag, "_bit0"});
    chk(K_OVR, 0, {tag, "_ovr_after_load"});
    joy_load_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic shift_edges(input logic [15:0] f, input int first, input int last, input string tag);
    for (int e = first; e <= last; e++) begin
      joy_clk = 1'b1;
      wait_clk(HALF);
      joy_clk = 1'b0;
      chk(K_DATA, (e < 16) ? int'(f[e]) : 1, $sformatf("%s_bit%0d", tag, e));
      if (e == 14) chk(K_FD, exp_fd, $sformatf("%s_fd_before15", tag));
      if (e == 15) begin
        exp_fd++;
        chk(K_FD, exp_fd, $sformatf("%s_fd_at15", tag));
      end
      if (e >= 17) chk(K_OVR, 1, $sformatf("%s_ovr_edge%0d", tag, e));
      if (e == 15) chk(K_OVR, 0, $sformatf("%s_ovr_edge15", tag));
      wait_clk(HALF - 4);
    end
  endtask

  task automatic run_frame(input logic [15:0] f, input int n, input string tag);
    begin_load(f, tag);
    shift_edges(f, 1, n, tag);
  endtask

  initial begin
    wait_clk(4);
    chk(K_DATA, 1, "reset_joy_data");
    chk(K_OVR, 0, "reset_overrun");
    chk(K_FD, 0, "reset_frame_done");
    chk(K_CNT, 0, "reset_bit_cnt");
    reset = 1'b0;
    wait_clk(8);

    run_frame(16'hFFFF, 15, "idle");
    run_frame(16'hC35A, 15, "pattern");

    // Live input change during load.
    joy1 = 8'hFF;
    joy2 = 8'h00;
    joy_load_n = 1'b0;
    wait_clk(2 * HALF);
    chk(K_DATA, 1, "live_before");
    joy1 = 8'hFE;
    wait_clk(2);
    chk(K_DATA, 0, "live_follow");
    wait_clk(HALF);
    joy_load_n = 1'b1;
    wait_clk(HALF);
    shift_edges(16'h00FE, 1, 15, "live");

    run_frame(16'h6B2D, 18, "overrun");
    run_frame(16'h4C1E, 15, "after_ovr");

    begin_load(16'h3CA5, "midrst");
    shift_edges(16'h3CA5, 1, 5, "midrst");
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    chk(K_DATA, 1, "midrst_joy_data");
    chk(K_CNT, 0, "midrst_bit_cnt");
    chk(K_OVR, 0, "midrst_overrun");
    run_frame(16'h9E61, 15, "post_rst");

    begin_load(16'hF0F0, "pre_simul");
    shift_edges(16'hF0F0, 1, 3, "pre_simul");
    joy1 = 8'h35;
    joy2 = 8'h12;
    joy_load_n = 1'b0;
    joy_clk = 1'b1;
    wait_clk(10);
    chk(K_DATA, 1, "simul_bit0");
    chk(K_CNT, 0, "simul_bit_cnt");
    joy_clk = 1'b0;
    wait_clk(2 * HALF);
    joy_load_n = 1'b1;
    wait_clk(HALF);
    shift_edges(16'h1235, 1, 15, "simul");

    wait_clk(8);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
